// File: rtl/jtag_lock_pkg.sv
// Shared types and helpers for the debug-lock register bank.
package jtag_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } lock_state_t;

  function automatic int chsel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtag_lock_regbank_if.sv
// Debug write path and unlock handshake bundle.
interface jtag_lock_regbank_if #(
  parameter int WIDTH  = 6,
  parameter int NUM_CH = 4
) ();
  localparam int CW = jtag_lock_pkg::chsel_w(NUM_CH);

  logic                    en;
  logic [CW-1:0]           ch_sel;
  logic [WIDTH-1:0]        write_data;
  logic                    unlock_req;
  logic [WIDTH-1:0]        unlock_key;
  logic                    relock;
  logic [NUM_CH*WIDTH-1:0] data;
  logic                    unlocked;
  logic                    locked_out;
  logic                    wr_err;

  modport master (
    output en, ch_sel, write_data,
    output unlock_req, unlock_key, relock,
    input  data, unlocked, locked_out, wr_err
  );

  modport slave (
    input  en, ch_sel, write_data,
    input  unlock_req, unlock_key, relock,
    output data, unlocked, locked_out, wr_err
  );
endinterface

// File: rtl/jtag_lock_fsm.sv
// Debug-lock FSM with key compare; lockout with JTAG_LOCK_LOCKOUT_EN.
module jtag_lock_fsm
  import jtag_lock_pkg::*;
#(
  parameter int               WIDTH          = 6,
  parameter logic [WIDTH-1:0] UNLOCK_KEY     = 6'h2A,
  parameter int               MAX_FAIL       = 3,
  parameter int               LOCKOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             unlock_req,
  input  logic [WIDTH-1:0] unlock_key,
  input  logic             relock,
  output lock_state_t      state,
  output logic             unlocked,
  output logic             locked_out
);

  lock_state_t      state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             unl_q;

`ifdef JTAG_LOCK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam logic [FW-1:0] MF = FW'(MAX_FAIL);
  localparam logic [TW-1:0] TL = TW'(LOCKOUT_CYCLES - 1);

  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          lko_q;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
`ifdef JTAG_LOCK_LOCKOUT_EN
    fail_d  = fail_q;
    tmr_d   = tmr_q;
`endif
    unique case (state_q)
      LOCKED: begin
        if (unlock_req) begin
          key_d   = unlock_key;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (key_q == UNLOCK_KEY) begin
          state_d = UNLOCKED;
`ifdef JTAG_LOCK_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          state_d = LOCKED;
`ifdef JTAG_LOCK_LOCKOUT_EN
          fail_d = (fail_q == MF) ? fail_q : fail_q + 1'b1;
          if (fail_d == MF) begin
            state_d = LOCKOUT;
            tmr_d   = TL;
          end
`endif
        end
      end
      UNLOCKED: begin
        if (relock) state_d = LOCKED;
      end
      LOCKOUT: begin
`ifdef JTAG_LOCK_LOCKOUT_EN
        if (tmr_q == '0) begin
          state_d = LOCKED;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`else
        state_d = LOCKED;
`endif
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCKED;
      key_q   <= '0;
      unl_q   <= 1'b0;
`ifdef JTAG_LOCK_LOCKOUT_EN
      fail_q  <= '0;
      tmr_q   <= '0;
      lko_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      unl_q   <= (state_d == UNLOCKED);
`ifdef JTAG_LOCK_LOCKOUT_EN
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      lko_q   <= (state_d == LOCKOUT);
`endif
    end
  end

  assign state    = state_q;
  assign unlocked = unl_q;
`ifdef JTAG_LOCK_LOCKOUT_EN
  assign locked_out = lko_q;
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: rtl/jtag_lock_regbank.sv
// Lock-protected register bank; lockout via JTAG_LOCK_LOCKOUT_EN.
module jtag_lock_regbank #(
  parameter int               WIDTH          = 6,
  parameter int               NUM_CH         = 4,
  parameter logic [WIDTH-1:0] UNLOCK_KEY     = 6'h2A,
  parameter int               MAX_FAIL       = 3,
  parameter int               LOCKOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  jtag_lock_regbank_if.slave bus
);
  import jtag_lock_pkg::*;

  lock_state_t state;

  logic [NUM_CH-1:0][WIDTH-1:0] data_q, data_d;
  logic                         wr_err_q, wr_err_d;
  logic                         acc;

  jtag_lock_fsm #(
    .WIDTH         (WIDTH),
    .UNLOCK_KEY    (UNLOCK_KEY),
    .MAX_FAIL      (MAX_FAIL),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .unlock_req(bus.unlock_req),
    .unlock_key(bus.unlock_key),
    .relock    (bus.relock),
    .state     (state),
    .unlocked  (bus.unlocked),
    .locked_out(bus.locked_out)
  );

  // The write sees the pre-edge state, so relock+en still lands.
  always_comb begin
    data_d = data_q;
    acc    = bus.en && (state == UNLOCKED) &&
             (int'(bus.ch_sel) < NUM_CH);
    if (acc) data_d[bus.ch_sel] = bus.write_data;
    wr_err_d = bus.en && !acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.data   = data_q;
  assign bus.wr_err = wr_err_q;

endmodule
